// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus write and read sequencers: state encoding,
// bus idle levels and default strobe timing.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StASetup,
    StAPulse,
    StAHold,
    StGap,
    StDSetup,
    StDPulse,
    StDHold,
    StDone
  } state_e;

  localparam logic       CS_IDLE  = 1'b1;
  localparam logic       WR_IDLE  = 1'b1;
  localparam logic       RD_IDLE  = 1'b1;
  localparam logic       AD_SEL_IDLE = 1'b1;
  localparam logic       OE_IDLE  = 1'b0;
  localparam logic [7:0] AD_IDLE  = 8'h00;

  localparam int unsigned DEF_T_SETUP = 2;
  localparam int unsigned DEF_T_PULSE = 4;
  localparam int unsigned DEF_T_HOLD  = 2;
  localparam int unsigned DEF_T_GAP   = 4;

  function automatic int unsigned max4(int unsigned a, int unsigned b,
                                       int unsigned c, int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rtc_bus_writer_phase_timer.sv
// Loadable down-counter timing one bus phase; expired is high once the count reaches zero.
module phase_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             expired
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_writer.sv
// Write master for the multiplexed address/data RTC bus: one request becomes an address
// strobe, an idle gap and a data strobe, with busy/done handshake to the controller.
module rtc_bus_writer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_PULSE = DEF_T_PULSE,
  parameter int unsigned T_HOLD  = DEF_T_HOLD,
  parameter int unsigned T_GAP   = DEF_T_GAP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d
);

  localparam int unsigned TMax = max4(T_SETUP, T_PULSE, T_HOLD, T_GAP);
  localparam int unsigned CntW = $clog2(TMax) + 1;

  // Load values are param-1 so a state lasting N cycles sees expired on its last cycle.
  localparam logic [CntW-1:0] LdSetup = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] LdPulse = CntW'(T_PULSE - 1);
  localparam logic [CntW-1:0] LdHold  = CntW'(T_HOLD - 1);
  localparam logic [CntW-1:0] LdGap   = CntW'(T_GAP - 1);

  state_e state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic            tmr_load;
  logic [CntW-1:0] tmr_value;
  logic            tmr_expired;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a_d_q, a_d_d;

  logic in_addr, in_data;

  phase_timer #(
    .Width(CntW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(tmr_value),
    .expired   (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d    = addr;
          wdata_d   = wdata;
          state_d   = StASetup;
          tmr_load  = 1'b1;
          tmr_value = LdSetup;
        end
      end
      StASetup: if (tmr_expired) begin
        state_d = StAPulse; tmr_load = 1'b1; tmr_value = LdPulse;
      end
      StAPulse: if (tmr_expired) begin
        state_d = StAHold; tmr_load = 1'b1; tmr_value = LdHold;
      end
      StAHold: if (tmr_expired) begin
        state_d = StGap; tmr_load = 1'b1; tmr_value = LdGap;
      end
      StGap: if (tmr_expired) begin
        state_d = StDSetup; tmr_load = 1'b1; tmr_value = LdSetup;
      end
      StDSetup: if (tmr_expired) begin
        state_d = StDPulse; tmr_load = 1'b1; tmr_value = LdPulse;
      end
      StDPulse: if (tmr_expired) begin
        state_d = StDHold; tmr_load = 1'b1; tmr_value = LdHold;
      end
      StDHold: if (tmr_expired) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registered bus lines up with the state.
  always_comb begin
    in_addr  = state_d inside {StASetup, StAPulse, StAHold};
    in_data  = state_d inside {StDSetup, StDPulse, StDHold};
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
    cs_n_d   = (in_addr || in_data) ? 1'b0 : CS_IDLE;
    ad_oe_d  = (in_addr || in_data) ? 1'b1 : OE_IDLE;
    a_d_d    = in_addr ? 1'b0 : AD_SEL_IDLE;
    wr_n_d   = (state_d inside {StAPulse, StDPulse}) ? 1'b0 : WR_IDLE;
    ad_out_d = AD_IDLE;
    if (in_addr) begin
      ad_out_d = addr_d;
    end else if (in_data) begin
      ad_out_d = wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ad_out_q <= AD_IDLE;
      ad_oe_q  <= OE_IDLE;
      cs_n_q   <= CS_IDLE;
      wr_n_q   <= WR_IDLE;
      a_d_q    <= AD_SEL_IDLE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      a_d_q    <= a_d_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign cs_n   = cs_n_q;
  assign rd_n   = RD_IDLE;
  assign wr_n   = wr_n_q;
  assign a_d    = a_d_q;

endmodule

// File: tb/tb_rtc_bus_writer.sv
// Bench for rtc_bus_writer: default-timing and minimum-timing instances share stimulus and
// are checked every cycle against a cycle-offset model, plus directed literal checks.
module tb_rtc_bus_writer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] addr;
  logic [7:0] wdata;

  obs_t o[2];

  int ts[2] = '{2, 1};
  int tp[2] = '{4, 1};
  int th[2] = '{2, 1};
  int tg[2] = '{4, 1};

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  bit         m_act[2];
  int         m_k[2];
  logic [7:0] m_a[2];
  logic [7:0] m_d[2];
  obs_t       prev[2];
  bit         have_prev = 1'b0;

  always #5 clk = ~clk;

  rtc_bus_writer u_dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .wdata(wdata),
    .busy(o[0].busy), .done(o[0].done), .ad_out(o[0].ad_out), .ad_oe(o[0].ad_oe),
    .cs_n(o[0].cs_n), .rd_n(o[0].rd_n), .wr_n(o[0].wr_n), .a_d(o[0].a_d)
  );

  rtc_bus_writer #(
    .T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)
  ) u_dut_fast (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .wdata(wdata),
    .busy(o[1].busy), .done(o[1].done), .ad_out(o[1].ad_out), .ad_oe(o[1].ad_oe),
    .cs_n(o[1].cs_n), .rd_n(o[1].rd_n), .wr_n(o[1].wr_n), .a_d(o[1].a_d)
  );

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic int latency(int i);
    return 2 * (ts[i] + tp[i] + th[i]) + tg[i] + 1;
  endfunction

  // Expected bus state k cycles after a request was accepted, purely from the timing rules.
  function automatic obs_t model_out(int i);
    obs_t e;
    int ph, j;
    e = '{busy: 1'b0, done: 1'b0, ad_out: 8'h00, ad_oe: 1'b0,
          cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a_d: 1'b1};
    if (m_act[i]) begin
      e.busy = 1'b1;
      ph = ts[i] + tp[i] + th[i];
      if (m_k[i] <= ph) begin
        e.cs_n = 1'b0; e.ad_oe = 1'b1; e.a_d = 1'b0; e.ad_out = m_a[i];
        e.wr_n = !(m_k[i] > ts[i] && m_k[i] <= ts[i] + tp[i]);
      end else if (m_k[i] > ph + tg[i] && m_k[i] <= 2 * ph + tg[i]) begin
        j = m_k[i] - ph - tg[i];
        e.cs_n = 1'b0; e.ad_oe = 1'b1; e.a_d = 1'b1; e.ad_out = m_d[i];
        e.wr_n = !(j > ts[i] && j <= ts[i] + tp[i]);
      end else if (m_k[i] == latency(i)) begin
        e.done = 1'b1;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i] <= 1'b0;
      end else if (m_act[i]) begin
        if (m_k[i] == latency(i)) m_act[i] <= 1'b0;
        else m_k[i] <= m_k[i] + 1;
      end else if (start) begin
        m_act[i] <= 1'b1;
        m_k[i]   <= 1;
        m_a[i]   <= addr;
        m_d[i]   <= wdata;
      end
    end
  end

  always @(negedge clk) begin
    obs_t e;
    for (int i = 0; i < 2; i++) begin
      e = model_out(i);
      chk($sformatf("dut%0d busy", i),   32'(o[i].busy),   32'(e.busy));
      chk($sformatf("dut%0d done", i),   32'(o[i].done),   32'(e.done));
      chk($sformatf("dut%0d ad_out", i), 32'(o[i].ad_out), 32'(e.ad_out));
      chk($sformatf("dut%0d ad_oe", i),  32'(o[i].ad_oe),  32'(e.ad_oe));
      chk($sformatf("dut%0d cs_n", i),   32'(o[i].cs_n),   32'(e.cs_n));
      chk($sformatf("dut%0d rd_n", i),   32'(o[i].rd_n),   32'(e.rd_n));
      chk($sformatf("dut%0d wr_n", i),   32'(o[i].wr_n),   32'(e.wr_n));
      chk($sformatf("dut%0d a_d", i),    32'(o[i].a_d),    32'(e.a_d));
      // Falling wr_n must see a stable bus from the previous cycle.
      if (have_prev && prev[i].wr_n === 1'b1 && o[i].wr_n === 1'b0) begin
        chk($sformatf("dut%0d wr_fall stable", i),
            {o[i].cs_n, o[i].a_d, o[i].ad_out},
            {prev[i].cs_n, prev[i].a_d, prev[i].ad_out});
      end
      prev[i] = o[i];
    end
    have_prev = 1'b1;
    if (o[0].done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle(int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; addr = 8'h00; wdata = 8'h00;
    tick(); tick(); tick();
    chk("reset cs_n", 32'(o[0].cs_n), 32'd1);
    chk("reset a_d", 32'(o[0].a_d), 32'd1);
    chk("reset busy", 32'(o[0].busy), 32'd0);
    reset = 1'b0;
    tick();

    // Basic transaction; fast instance runs alongside.
    start = 1'b1; addr = 8'h25; wdata = 8'h07;
    for (int n = 1; n <= 22; n++) begin
      tick();
      start = 1'b0;
      if (n == 1)  chk("t1 c1 addr", {o[0].cs_n, o[0].a_d, o[0].ad_out}, {1'b0, 1'b0, 8'h25});
      if (n == 2)  chk("t1 c2 wr_n", 32'(o[0].wr_n), 32'd1);
      if (n == 3)  chk("t1 c3 wr_n", 32'(o[0].wr_n), 32'd0);
      if (n == 7)  chk("t1 c7 wr_n", 32'(o[0].wr_n), 32'd1);
      if (n == 9)  chk("t1 c9 gap", {o[0].cs_n, o[0].ad_oe, o[0].ad_out}, {1'b1, 1'b0, 8'h00});
      if (n == 13) chk("t1 c13 data", {o[0].cs_n, o[0].a_d, o[0].ad_out}, {1'b0, 1'b1, 8'h07});
      if (n == 15) chk("t1 c15 wr_n", 32'(o[0].wr_n), 32'd0);
      if (n == 20) chk("t1 c20 done", 32'(o[0].done), 32'd0);
      if (n == 21) chk("t1 c21 done", {o[0].done, o[0].busy, o[0].cs_n}, {1'b1, 1'b1, 1'b1});
      if (n == 22) chk("t1 c22 busy", 32'(o[0].busy), 32'd0);
      if (n == 7)  chk("fast c7 done", 32'(o[1].done), 32'd0);
      if (n == 8)  chk("fast c8 done", 32'(o[1].done), 32'd1);
    end
    settle(12);

    // Starts while busy are ignored; addr/wdata changes after acceptance are ignored.
    d0 = done_cnt;
    start = 1'b1; addr = 8'h25; wdata = 8'h07;
    for (int n = 1; n <= 22; n++) begin
      tick();
      start = (n == 5 || n == 21);
      if (n == 2) begin addr = 8'hFF; wdata = 8'hFF; end
      if (n == 5 || n == 21) begin addr = 8'h99; wdata = 8'h99; end
      if (n == 7)  chk("t2 c7 addr", 32'(o[0].ad_out), 32'h25);
      if (n == 14) chk("t2 c14 data", 32'(o[0].ad_out), 32'h07);
    end
    chk("t2 done pulses", 32'(done_cnt - d0), 32'd1);
    settle(12);

    // Reset inside the data write pulse.
    d0 = done_cnt;
    start = 1'b1; addr = 8'h25; wdata = 8'h07;
    for (int n = 1; n <= 24; n++) begin
      tick();
      start = 1'b0;
      reset = (n == 16);
      if (n == 17) chk("t4 c17 idle", {o[0].cs_n, o[0].wr_n, o[0].ad_oe, o[0].busy},
                       {1'b1, 1'b1, 1'b0, 1'b0});
    end
    chk("t4 no done", 32'(done_cnt - d0), 32'd0);
    settle(4);

    // start held high: back-to-back acceptance.
    d0 = done_cnt;
    start = 1'b1; addr = 8'h26; wdata = 8'h12;
    for (int n = 1; n <= 45; n++) begin
      tick();
      start = (n < 43);
      if (n == 21) chk("t5 c21 done", 32'(o[0].done), 32'd1);
      if (n == 22) chk("t5 c22 idle", {o[0].busy, o[0].cs_n}, {1'b0, 1'b1});
      if (n == 23) chk("t5 c23 cs_n", {o[0].cs_n, o[0].ad_out}, {1'b0, 8'h26});
      if (n == 43) chk("t5 c43 done", 32'(o[0].done), 32'd1);
    end
    chk("t5 done pulses", 32'(done_cnt - d0), 32'd2);
    settle(12);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
